// File: rtl/q_measure_avg.sv
// q_measure_avg
// ---------------------------------------------------------------------------
// Front end of the instability detector. Each time the reference current
// (i_ref_setup) changes, the block waits SETTLE_CYCLES cycles for the analog
// path to settle. It then averages 2^AVG_LOG2 accepted ADC samples and
// publishes the mean on q_measured, with a single-cycle q_valid strobe.
// While enable stays high, a new averaging window starts immediately after
// each completed one.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   enable       in   run request; low returns the block to IDLE
//   i_ref_setup  in   [WIDTH]     reference currently applied downstream
//   adc_data     in   [ADC_WIDTH] raw Q sample
//   adc_valid    in   adc_data qualifier, only looked at while accumulating
//   q_measured   out  [WIDTH]     last completed average (registered)
//   q_valid      out  one-cycle strobe, high when q_measured was just updated
//   busy         out  high while settling or accumulating
//
// Handshake: adc_data is consumed on every rising edge where adc_valid is high
// and the block is in ACCUM. There is no back-pressure. q_valid is a pure
// strobe that is high for exactly one cycle per completed window, and
// q_measured stays stable between strobes.
// ---------------------------------------------------------------------------
module q_measure_avg #(
  parameter int WIDTH         = 10,
  parameter int ADC_WIDTH     = 10,
  parameter int AVG_LOG2      = 3,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     i_ref_setup,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 adc_valid,
  output logic [WIDTH-1:0]     q_measured,
  output logic                 q_valid,
  output logic                 busy
);

  localparam int AW = ADC_WIDTH + AVG_LOG2;  // holds 2^AVG_LOG2 full-scale samples
  localparam int CW = AVG_LOG2 + 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'((1 << AVG_LOG2) - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] iref_q, iref_d;
  logic [WIDTH-1:0] qm_q, qm_d;
  logic             qv_q, qv_d;
  logic             busy_q;
  logic [AW-1:0]    sum;

  assign sum = acc_q + AW'(adc_data);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    iref_d   = iref_q;
    qm_d     = qm_q;
    qv_d     = 1'b0;

    // Priority: enable low, then a reference change, then normal progress.
    if (!enable) begin
      state_d  = ST_IDLE;
      settle_d = '0;
      cnt_d    = '0;
      acc_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_SETTLE;
          iref_d   = i_ref_setup;
          settle_d = SETTLE_LOAD;
        end
        default: begin
          if (i_ref_setup != iref_q) begin
            // Restart settling and discard the partial window.
            state_d  = ST_SETTLE;
            iref_d   = i_ref_setup;
            settle_d = SETTLE_LOAD;
            cnt_d    = '0;
            acc_d    = '0;
          end else if (state_q == ST_SETTLE) begin
            if (settle_q == '0) begin
              state_d = ST_ACCUM;
              cnt_d   = '0;
              acc_d   = '0;
            end else begin
              settle_d = settle_q - SW'(1);
            end
          end else if (adc_valid) begin
            if (cnt_q == LAST_SAMPLE) begin
              // Mean is sum >> AVG_LOG2. Keep its top WIDTH bits (floor rounding).
              qm_d  = sum[AW-1 -: WIDTH];
              qv_d  = 1'b1;
              cnt_d = '0;
              acc_d = '0;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      iref_q   <= '0;
      qm_q     <= '0;
      qv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      iref_q   <= iref_d;
      qm_q     <= qm_d;
      qv_q     <= qv_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign q_measured = qm_q;
  assign q_valid    = qv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_q_measure_avg.sv
module tb_q_measure_avg;

  localparam int WIDTH         = 10;
  localparam int ADC_WIDTH     = 10;
  localparam int AVG_LOG2      = 3;
  localparam int SETTLE_CYCLES = 16;
  localparam int NSAMP         = 1 << AVG_LOG2;
  localparam int LATENCY       = 1 + SETTLE_CYCLES + NSAMP;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic [WIDTH-1:0]     i_ref_setup;
  logic [ADC_WIDTH-1:0] adc_data;
  logic                 adc_valid;
  logic [WIDTH-1:0]     q_measured;
  logic                 q_valid;
  logic                 busy;

  always #5 clk = ~clk;

  q_measure_avg #(
    .WIDTH(WIDTH), .ADC_WIDTH(ADC_WIDTH),
    .AVG_LOG2(AVG_LOG2), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .i_ref_setup(i_ref_setup),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .q_measured(q_measured), .q_valid(q_valid), .busy(busy)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Mode 0 = idle, 1 = waiting for settle, 2 = collecting samples.
  logic [WIDTH-1:0] exp_q[$];
  int               m_mode      = 0;
  int               m_settle_left = 0;
  int               m_iref_last = 0;
  int               samples[$];
  logic [WIDTH-1:0] m_last_q    = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      m_iref_last = 0;
      m_last_q = '0;
      samples.delete();
      exp_q.delete();
    end else if (!enable) begin
      m_mode = 0;
      samples.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_settle_left = SETTLE_CYCLES;
      m_iref_last = int'(i_ref_setup);
    end else if (int'(i_ref_setup) != m_iref_last) begin
      m_mode = 1;
      m_settle_left = SETTLE_CYCLES;
      m_iref_last = int'(i_ref_setup);
      samples.delete();
    end else if (m_mode == 1) begin
      m_settle_left--;
      if (m_settle_left == 0) m_mode = 2;
    end else if (adc_valid) begin
      samples.push_back(int'(adc_data));
      if (samples.size() == NSAMP) begin
        int s;
        int mean;
        s = 0;
        foreach (samples[k]) s += samples[k];
        mean = s / NSAMP;
        m_last_q = WIDTH'(mean >> (ADC_WIDTH - WIDTH));
        exp_q.push_back(m_last_q);
        samples.delete();
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_qv = 1'b0;

  always @(negedge clk) begin
    check("busy", int'(busy), int'(m_mode != 0));
    check("q_measured_hold", int'(q_measured), int'(m_last_q));
    if (q_valid) begin
      check("q_valid_single", int'(prev_qv), 0);
      if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
      else check("strobe_value", int'(q_measured), int'(exp_q.pop_front()));
    end else if (exp_q.size() != 0) begin
      check("missing_strobe", 0, int'(exp_q.pop_front()));
    end
    prev_qv = q_valid;
  end

  // ---------------- driver tasks ----------------
  // Counts falling edges until q_valid is seen; the first counted negedge
  // follows the first rising edge after the call.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!q_valid && n < 200);
    if (!q_valid) check("strobe_timeout", 0, 1);
  endtask

  task automatic feed(input int count, input int value);
    for (int i = 0; i < count; i++) begin
      adc_data  = ADC_WIDTH'(value);
      adc_valid = 1'b1;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int held;
    rst = 1'b1; enable = 1'b0; i_ref_setup = '0; adc_data = '0; adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_q_measured", int'(q_measured), 0);
    check("reset_q_valid", int'(q_valid), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Constant input, latency and period.
    i_ref_setup = 10'd5; adc_data = 10'd400; adc_valid = 1'b1; enable = 1'b1;
    wait_strobe(n);
    check("first_latency", n, LATENCY);
    check("const_value", int'(q_measured), 400);
    wait_strobe(n);
    check("period", n, NSAMP);

    // Ramp 100..107 -> 103.
    for (int i = 0; i < NSAMP; i++) feed(1, 100 + i);
    check("ramp_strobe", int'(q_valid), 1);
    check("ramp_value", int'(q_measured), 103);

    // Full scale, no wrap.
    feed(NSAMP, 1023);
    check("full_scale_strobe", int'(q_valid), 1);
    check("full_scale_value", int'(q_measured), 1023);

    // Gapped valid starting with a gap: 8th sample lands on edge 16.
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      adc_valid = (i % 2 == 0);
      adc_data  = ADC_WIDTH'($urandom_range(0, 1023));
      @(negedge clk);
      n = i;
      if (q_valid) break;
    end
    check("gapped_latency", n, 2 * NSAMP);

    // i_ref change after 4 samples aborts the window.
    feed(4, 200);
    i_ref_setup = 10'd6;
    wait_strobe(n);
    check("iref_abort_latency", n, LATENCY);

    // i_ref change on the completing sample: change wins.
    feed(NSAMP - 1, 300);
    i_ref_setup = 10'd7;
    adc_data = 10'd300;
    wait_strobe(n);
    check("iref_coincide_latency", n, LATENCY);

    // enable drop mid-ACCUM.
    held = int'(q_measured);
    feed(3, 50);
    enable = 1'b0;
    @(negedge clk);
    check("disable_busy", int'(busy), 0);
    check("disable_hold", int'(q_measured), held);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    adc_data = 10'd640;
    wait_strobe(n);
    check("reenable_latency", n, LATENCY);
    check("reenable_value", int'(q_measured), 640);

    // Asynchronous reset between edges mid-ACCUM.
    feed(3, 10);
    check("pre_reset_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_q_measured", int'(q_measured), 0);
    check("async_rst_q_valid", int'(q_valid), 0);
    check("async_rst_busy", int'(busy), 0);
    #1 rst = 1'b0;
    wait_strobe(n);
    check("post_reset_latency", n, LATENCY);

    // Randomized traffic with occasional i_ref changes and enable drops.
    for (int i = 0; i < 1500; i++) begin
      adc_data  = ADC_WIDTH'($urandom_range(0, 1023));
      adc_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 119) == 0) i_ref_setup = WIDTH'($urandom_range(0, 1023));
      enable = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end

    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
